// File: rtl/parser_typedefs_pkg.sv
// Shared parser/flow-table types: the PHS key layout, flow-table FSM states and entry format.
package parser_typedefs_pkg;

  localparam int PHS_WIDTH      = 120;
  localparam int FLOW_CNT_WIDTH = 32;

  typedef struct packed {
    logic [7:0]  phs_type;
    logic [7:0]  tos;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } PHS_Struct;

  typedef enum logic [1:0] {
    FT_IDLE   = 2'd0,
    FT_SEARCH = 2'd1,
    FT_UPDATE = 2'd2
  } FT_STATES;

  typedef struct packed {
    logic                      valid;
    PHS_Struct                 key;
    logic [FLOW_CNT_WIDTH-1:0] cnt;
  } FlowEntry;

  function automatic logic phs_key_match(input logic valid, input PHS_Struct entry_key,
                                         input PHS_Struct key);
    return valid && (entry_key == key);
  endfunction

endpackage

// File: rtl/phs_flow_table_if.sv
// Key input, lookup result, counter read-back and status signals of the flow table.
interface phs_flow_table_if #(
  parameter int FLOW_ENTRIES = 16,
  parameter int CNT_WIDTH    = 32
);
  import parser_typedefs_pkg::*;

  localparam int IW = $clog2(FLOW_ENTRIES);

  logic [PHS_WIDTH-1:0] phs_i;
  logic                 phs_valid_i;
  logic                 flush_i;
  logic [IW-1:0]        flow_id_o;
  logic                 flow_hit_o;
  logic                 flow_new_o;
  logic                 flow_drop_o;
  logic                 result_valid_o;
  logic [IW-1:0]        cnt_rd_idx_i;
  logic [CNT_WIDTH-1:0] cnt_rd_data_o;
  logic [15:0]          fifo_drop_cnt_o;
  logic                 table_full_o;

  modport slave (
    input  phs_i, phs_valid_i, flush_i, cnt_rd_idx_i,
    output flow_id_o, flow_hit_o, flow_new_o, flow_drop_o, result_valid_o,
           cnt_rd_data_o, fifo_drop_cnt_o, table_full_o
  );

  modport master (
    output phs_i, phs_valid_i, flush_i, cnt_rd_idx_i,
    input  flow_id_o, flow_hit_o, flow_new_o, flow_drop_o, result_valid_o,
           cnt_rd_data_o, fifo_drop_cnt_o, table_full_o
  );

endinterface

// File: rtl/phs_fifo.sv
// Small synchronous FIFO buffering PHS keys ahead of the flow-table search.
module phs_fifo #(
  parameter int WIDTH = 120,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/phs_flow_table.sv
// Fully associative flow table: sequential search, learn-on-miss into the first free slot,
// saturating per-flow packet counters.
module phs_flow_table
  import parser_typedefs_pkg::*;
#(
  parameter int FLOW_ENTRIES = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 32
) (
  input logic              CLK,
  input logic              reset,
  phs_flow_table_if.slave  ft
);

  localparam int IW = $clog2(FLOW_ENTRIES);

  FT_STATES             state_q, state_d;
  PHS_Struct            key_q, key_d;
  logic [IW-1:0]        idx_q, idx_d, free_idx_q, free_idx_d, res_idx_q, res_idx_d;
  logic                 free_found_q, free_found_d, hit_q, hit_d;
  logic [IW-1:0]        flow_id_q, flow_id_d;
  logic                 flow_hit_q, flow_hit_d, flow_new_q, flow_new_d;
  logic                 flow_drop_q, flow_drop_d;
  logic                 result_valid_q, result_valid_d;
  logic                 table_full_q, table_full_d;
  logic [15:0]          fifo_drop_cnt_q, fifo_drop_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_rd_data_q;

  logic                 valid_q [FLOW_ENTRIES];
  PHS_Struct            tkey_q  [FLOW_ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q   [FLOW_ENTRIES];
  logic [FLOW_ENTRIES-1:0] valid_nx;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [PHS_WIDTH-1:0] fifo_data;
  logic                 learn_en, hit_en, entry_match;

  phs_fifo #(
    .WIDTH (PHS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .reset   (reset),
    .push_i  (ft.phs_valid_i),
    .data_i  (ft.phs_i),
    .pop_i   (fifo_pop),
    .flush_i (ft.flush_i),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign entry_match = phs_key_match(valid_q[idx_q], tkey_q[idx_q], key_q);

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    idx_d          = idx_q;
    free_idx_d     = free_idx_q;
    free_found_d   = free_found_q;
    hit_d          = hit_q;
    res_idx_d      = res_idx_q;
    flow_id_d      = flow_id_q;
    flow_hit_d     = flow_hit_q;
    flow_new_d     = flow_new_q;
    flow_drop_d    = flow_drop_q;
    result_valid_d = 1'b0;
    fifo_pop       = 1'b0;
    learn_en       = 1'b0;
    hit_en         = 1'b0;

    if (ft.flush_i) begin
      state_d = FT_IDLE;
    end else begin
      unique case (state_q)
        FT_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            key_d        = PHS_Struct'(fifo_data);
            idx_d        = '0;
            free_found_d = 1'b0;
            hit_d        = 1'b0;
            state_d      = FT_SEARCH;
          end
        end
        FT_SEARCH: begin
          if (!valid_q[idx_q] && !free_found_q) begin
            free_idx_d   = idx_q;
            free_found_d = 1'b1;
          end
          if (entry_match) begin
            hit_d     = 1'b1;
            res_idx_d = idx_q;
            state_d   = FT_UPDATE;
          end else if (idx_q == IW'(FLOW_ENTRIES - 1)) begin
            state_d = FT_UPDATE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        FT_UPDATE: begin
          state_d        = FT_IDLE;
          result_valid_d = 1'b1;
          flow_hit_d     = 1'b0;
          flow_new_d     = 1'b0;
          flow_drop_d    = 1'b0;
          if (hit_q) begin
            hit_en     = 1'b1;
            flow_id_d  = res_idx_q;
            flow_hit_d = 1'b1;
          end else if (free_found_q) begin
            learn_en   = 1'b1;
            flow_id_d  = free_idx_q;
            flow_new_d = 1'b1;
          end else begin
            flow_id_d   = '0;
            flow_drop_d = 1'b1;
          end
        end
        default: state_d = FT_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_drop_cnt_d = fifo_drop_cnt_q;
    if (ft.phs_valid_i && !ft.flush_i && fifo_full && !fifo_pop && fifo_drop_cnt_q != 16'hFFFF)
      fifo_drop_cnt_d = fifo_drop_cnt_q + 16'd1;
    // Full flag tracks the valid bits as they will be after this cycle's learn.
    table_full_d = ft.flush_i ? 1'b0 : &valid_nx;
  end

  for (genvar gi = 0; gi < FLOW_ENTRIES; gi++) begin : g_entry
    assign valid_nx[gi] = valid_q[gi] || (learn_en && free_idx_q == IW'(gi));

    always_ff @(posedge CLK) begin
      if (!reset || ft.flush_i) begin
        valid_q[gi] <= 1'b0;
        cnt_q[gi]   <= '0;
      end else if (learn_en && free_idx_q == IW'(gi)) begin
        valid_q[gi] <= 1'b1;
        cnt_q[gi]   <= CNT_WIDTH'(1);
      end else if (hit_en && res_idx_q == IW'(gi) && cnt_q[gi] != '1) begin
        cnt_q[gi] <= cnt_q[gi] + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge CLK) begin
      if (learn_en && free_idx_q == IW'(gi)) tkey_q[gi] <= key_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q         <= FT_IDLE;
      key_q           <= '0;
      idx_q           <= '0;
      free_idx_q      <= '0;
      free_found_q    <= 1'b0;
      hit_q           <= 1'b0;
      res_idx_q       <= '0;
      flow_id_q       <= '0;
      flow_hit_q      <= 1'b0;
      flow_new_q      <= 1'b0;
      flow_drop_q     <= 1'b0;
      result_valid_q  <= 1'b0;
      table_full_q    <= 1'b0;
      fifo_drop_cnt_q <= '0;
      cnt_rd_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      idx_q           <= idx_d;
      free_idx_q      <= free_idx_d;
      free_found_q    <= free_found_d;
      hit_q           <= hit_d;
      res_idx_q       <= res_idx_d;
      flow_id_q       <= flow_id_d;
      flow_hit_q      <= flow_hit_d;
      flow_new_q      <= flow_new_d;
      flow_drop_q     <= flow_drop_d;
      result_valid_q  <= result_valid_d;
      table_full_q    <= table_full_d;
      fifo_drop_cnt_q <= fifo_drop_cnt_d;
      cnt_rd_data_q   <= cnt_q[ft.cnt_rd_idx_i];
    end
  end

  assign ft.flow_id_o       = flow_id_q;
  assign ft.flow_hit_o      = flow_hit_q;
  assign ft.flow_new_o      = flow_new_q;
  assign ft.flow_drop_o     = flow_drop_q;
  assign ft.result_valid_o  = result_valid_q;
  assign ft.cnt_rd_data_o   = cnt_rd_data_q;
  assign ft.fifo_drop_cnt_o = fifo_drop_cnt_q;
  assign ft.table_full_o    = table_full_q;

endmodule

// File: tb/tb_phs_flow_table.sv
// Self-checking bench for phs_flow_table: vector table plus scoreboard of expected lookup results.
module tb_phs_flow_table;

  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phs_flow_table_if #(.FLOW_ENTRIES(N), .CNT_WIDTH(32)) ft_if ();

  phs_flow_table #(
    .FLOW_ENTRIES (N),
    .FIFO_DEPTH   (4),
    .CNT_WIDTH    (32)
  ) dut (
    .CLK   (clk),
    .reset (rst_n),
    .ft    (ft_if)
  );

  // lat > 0: required cycles from capture to result; 0: order-only; -1: lost to a full FIFO
  typedef struct {
    logic [119:0] key;
    logic         hit;
    logic         nw;
    logic         drop;
    logic [3:0]   id;
    int           lat;
  } vec_t;

  typedef struct {
    logic       hit;
    logic       nw;
    logic       drop;
    logic [3:0] id;
    int         lat;
    int         pcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   txn    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] mk_key(input logic [7:0] tos, input logic [15:0] sp,
                                          input logic [15:0] dp, input logic [7:0] pr,
                                          input logic [31:0] sip, input logic [31:0] dip);
    return {8'h03, tos, sp, dp, pr, sip, dip};
  endfunction

  always @(negedge clk) begin
    if (ft_if.result_valid_o) begin
      txn++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d hit=%0b new=%0b drop=%0b at cycle %0d, required no result",
                 ft_if.flow_id_o, ft_if.flow_hit_o, ft_if.flow_new_o, ft_if.flow_drop_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn %0d: cycle %0d id=%0d hit=%0b new=%0b drop=%0b", txn, cyc,
                 ft_if.flow_id_o, ft_if.flow_hit_o, ft_if.flow_new_o, ft_if.flow_drop_o);
        chk("flow_hit", 64'(ft_if.flow_hit_o), 64'(mon_e.hit));
        chk("flow_new", 64'(ft_if.flow_new_o), 64'(mon_e.nw));
        chk("flow_drop", 64'(ft_if.flow_drop_o), 64'(mon_e.drop));
        chk("flow_id", 64'(ft_if.flow_id_o), 64'(mon_e.id));
        if (mon_e.lat > 0) chk("latency", 64'(cyc - mon_e.pcyc), 64'(mon_e.lat));
      end
    end
  end

  // Drive a strobe now (just after an edge); queue its expectation once captured.
  task automatic push_now(input vec_t v, input logic expect_result);
    exp_t e;
    ft_if.phs_i       = v.key;
    ft_if.phs_valid_i = 1'b1;
    @(posedge clk);
    #1;
    ft_if.phs_valid_i = 1'b0;
    if (expect_result && v.lat >= 0) begin
      e.hit  = v.hit;
      e.nw   = v.nw;
      e.drop = v.drop;
      e.id   = v.id;
      e.lat  = v.lat;
      e.pcyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic push_key(input vec_t v, input logic expect_result);
    @(posedge clk);
    #1;
    push_now(v, expect_result);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [3:0] idx, input logic [31:0] exp);
    @(posedge clk);
    #1 ft_if.cnt_rd_idx_i = idx;
    @(posedge clk);
    #1 chk($sformatf("cnt[%0d]", idx), 64'(ft_if.cnt_rd_data_o), 64'(exp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_result_valid"}, 64'(ft_if.result_valid_o), 64'd0);
    chk({tag, "_flow_hit"}, 64'(ft_if.flow_hit_o), 64'd0);
    chk({tag, "_flow_new"}, 64'(ft_if.flow_new_o), 64'd0);
    chk({tag, "_flow_drop"}, 64'(ft_if.flow_drop_o), 64'd0);
    chk({tag, "_flow_id"}, 64'(ft_if.flow_id_o), 64'd0);
    chk({tag, "_table_full"}, 64'(ft_if.table_full_o), 64'd0);
    chk({tag, "_fifo_drop_cnt"}, 64'(ft_if.fifo_drop_cnt_o), 64'd0);
    chk({tag, "_cnt_rd_data"}, 64'(ft_if.cnt_rd_data_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [7];
    vec_t         burst [6];
    vec_t         v;
    logic [119:0] ka, kb, kc, kd, ke, kx, ky, kn;
    logic [119:0] fill [12];

    ft_if.phs_i        = '0;
    ft_if.phs_valid_i  = 1'b0;
    ft_if.flush_i      = 1'b0;
    ft_if.cnt_rd_idx_i = '0;

    ka = mk_key(8'h00, 16'd1000, 16'd2000, 8'd17, 32'h0A000001, 32'h0A000002);
    kb = mk_key(8'h00, 16'd1000, 16'd2001, 8'd17, 32'h0A000001, 32'h0A000002);
    kc = mk_key(8'h10, 16'd1000, 16'd2000, 8'd17, 32'h0A000001, 32'h0A000002);
    kd = mk_key(8'h00, 16'd1000, 16'd2000, 8'd6,  32'h0A000001, 32'h0A000002);
    ke = mk_key(8'h00, 16'd5000, 16'd53,   8'd17, 32'hAC100001, 32'h08080808);
    kx = mk_key(8'h00, 16'd5001, 16'd53,   8'd17, 32'hAC100002, 32'h08080808);
    ky = mk_key(8'h00, 16'd5002, 16'd53,   8'd17, 32'hAC100003, 32'h08080808);
    kn = mk_key(8'h00, 16'd5003, 16'd53,   8'd17, 32'hAC100004, 32'h08080808);
    for (int i = 0; i < 12; i++)
      fill[i] = mk_key(8'h00, 16'(3000 + i), 16'd80, 8'd6, 32'hC0A80000 + 32'(i), 32'h0A0000FE);

    vecs[0] = '{ka, 1'b0, 1'b1, 1'b0, 4'd0, 18};
    vecs[1] = '{ka, 1'b1, 1'b0, 1'b0, 4'd0, 3};
    vecs[2] = '{kb, 1'b0, 1'b1, 1'b0, 4'd1, 18};
    vecs[3] = '{kb, 1'b1, 1'b0, 1'b0, 4'd1, 4};
    vecs[4] = '{ka, 1'b1, 1'b0, 1'b0, 4'd0, 3};
    vecs[5] = '{kc, 1'b0, 1'b1, 1'b0, 4'd2, 18};
    vecs[6] = '{kd, 1'b0, 1'b1, 1'b0, 4'd3, 18};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Isolated lookups: learn, hit at various indices, single-field differences
    for (int i = 0; i < 7; i++) begin
      push_key(vecs[i], 1'b1);
      wait_drain(40);
    end
    chk_cnt(4'd0, 32'd3);
    chk_cnt(4'd1, 32'd2);
    chk_cnt(4'd2, 32'd1);

    // Fill the remaining slots
    for (int i = 0; i < 12; i++) begin
      v = '{fill[i], 1'b0, 1'b1, 1'b0, 4'(4 + i), 18};
      push_key(v, 1'b1);
      wait_drain(40);
    end
    chk("full_after_fill", 64'(ft_if.table_full_o), 64'd1);

    // Miss on a full table, then hit on the last entry
    v = '{ke, 1'b0, 1'b0, 1'b1, 4'd0, 18};
    push_key(v, 1'b1);
    wait_drain(40);
    chk("full_after_drop", 64'(ft_if.table_full_o), 64'd1);
    chk("fifo_drop_after_fill", 64'(ft_if.fifo_drop_cnt_o), 64'd0);
    v = '{fill[11], 1'b1, 1'b0, 1'b0, 4'd15, 18};
    push_key(v, 1'b1);
    wait_drain(40);

    // Six consecutive strobes while a miss search runs: four queue, two are lost
    burst[0] = '{ka,      1'b1, 1'b0, 1'b0, 4'd0, 0};
    burst[1] = '{kn,      1'b0, 1'b0, 1'b1, 4'd0, 0};
    burst[2] = '{fill[1], 1'b1, 1'b0, 1'b0, 4'd5, 0};
    burst[3] = '{kb,      1'b1, 1'b0, 1'b0, 4'd1, 0};
    burst[4] = '{ky,      1'b0, 1'b0, 1'b1, 4'd0, -1};
    burst[5] = '{kn,      1'b0, 1'b0, 1'b1, 4'd0, -1};
    v = '{kx, 1'b0, 1'b0, 1'b1, 4'd0, 18};
    push_key(v, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) push_now(burst[i], 1'b1);
    wait_drain(200);
    chk("fifo_drop_after_burst", 64'(ft_if.fifo_drop_cnt_o), 64'd2);
    chk_cnt(4'd0, 32'd4);
    chk_cnt(4'd5, 32'd2);

    // Flush in the middle of a miss search: no result, table emptied
    v = '{ky, 1'b0, 1'b0, 1'b1, 4'd0, 18};
    push_key(v, 1'b0);
    repeat (5) @(posedge clk);
    #1 ft_if.flush_i = 1'b1;
    @(posedge clk);
    #1 ft_if.flush_i = 1'b0;
    chk("full_after_flush", 64'(ft_if.table_full_o), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk_cnt(4'd0, 32'd0);
    v = '{ka, 1'b0, 1'b1, 1'b0, 4'd0, 18};
    push_key(v, 1'b1);
    wait_drain(40);
    chk_cnt(4'd0, 32'd1);

    // Reset asserted during the update cycle of a hit
    v = '{ka, 1'b1, 1'b0, 1'b0, 4'd0, 3};
    push_key(v, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_idle_outputs("midreset");
    repeat (5) @(posedge clk);
    #1;
    chk_cnt(4'd0, 32'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
